tape_loader: RTL
================

# tape_loader

Host-side sequencer driving the Turing-machine chip's pin-level input protocol. It buffers up to DEPTH 6-bit tape symbols written by a host. On `start` it presents them on the chip's data pins, one `Next` strobe per symbol, then issues one `Done` strobe. It then waits for the chip's `Compute_done` rising edge and captures the 11-bit display word. It sits on the FPGA/test-harness side of the chip pins: `tape_data` drives io_in[7:2], `next_out` drives io_in[1], `done_out` drives io_in[0], and `compute_done_in`/`display_in` come from io_out.

## Interface
- `WIDTH`, 6: tape symbol width.
- `DEPTH`, 64: symbol buffer capacity.
- `HOLD`, 4: cycles each pin phase is held. Must be ≥3 so the chip's 2-flop synchronizers capture every level.
- `TIMEOUT`, 65535: maximum WAIT cycles before the error flag is raised.

Ports:
- `clock` in 1: sole clock.
- `reset_n` in 1: one clock; reset is asynchronous and active-low.
- `wr_en` in 1: append `wr_data` to the buffer.
- `wr_data` in WIDTH: symbol to append.
- `clear` in 1: empty the buffer.
- `start` in 1: begin a transmit/compute run.
- `busy` out 1: high from the cycle after an accepted `start` until the return to IDLE.
- `full` out 1: count == DEPTH.
- `tape_data` out WIDTH: chip data pins.
- `next_out` out 1: chip Next pin.
- `done_out` out 1: chip Done pin.
- `compute_done_in` in 1: chip Compute_done, asynchronous.
- `display_in` in 11: chip display_out, asynchronous.
- `result` out 11: captured display word.
- `result_valid` out 1: one-cycle pulse when `result` updates.
- `timeout_err` out 1: sticky; cleared by the next accepted `start`.

## Operation
- Reset values: all outputs 0; count 0; FSM in IDLE; `result` 0.
- Buffer:
  - Writes are accepted only in IDLE.
  - A `wr_en` while `busy` or `full` is dropped with no side effects.
  - `clear` is honoured only in IDLE and sets count to 0.
  - `clear` and `wr_en` in the same cycle: clear wins.
  - The buffer is retained across runs, so runs can repeat.
- `compute_done_in` passes through a 2-flop synchronizer, then an edge register. A rising edge is detected internally.
- `display_in` is sampled two cycles after the synchronized edge. This is its own 2-flop stage and needs no handshake.
- FSM states (phase counter counts HOLD cycles):
  - IDLE: accepts `start`, ignored when `clear` is asserted in the same cycle. Clears `timeout_err`, sets index to 0. Goes to SETUP if count>0, else GAP.
  - SETUP: `tape_data`=buf[index], `next_out`=0, for HOLD cycles, then PULSE.
  - PULSE: `tape_data` unchanged, `next_out`=1, for HOLD cycles. Then index+1; goes to SETUP if index+1<count, else GAP.
  - GAP: `next_out`=0, `done_out`=0, `tape_data` holds its last value, for HOLD cycles, then DONE.
  - DONE: `done_out`=1 for HOLD cycles, then WAIT.
  - WAIT: all strobes 0. On a synchronized rising edge, go to CAPTURE. When the wait counter reaches TIMEOUT, set `timeout_err` and go to IDLE.
  - CAPTURE: loads `result` from the synchronized display and pulses `result_valid`, then IDLE.
- A `Compute_done` level that is already high on entering WAIT is not an edge. The block waits for a low-then-high sequence.
- `start` while busy is ignored.
- `next_out` and `done_out` are never high in the same cycle.

## Timing
- All pin outputs are registered and glitch-free.
- `start` is sampled at edge t. `busy` and the first SETUP cycle appear at t+1.
- For N symbols, transmit lasts (2N+2)·HOLD cycles: `next_out` rises at t+1+HOLD, and `done_out` rises at t+1+2N·HOLD+HOLD.
- `tape_data` is stable for HOLD cycles before and throughout every `next_out` high.
- `result_valid` is 1 cycle. `busy` drops in the cycle after CAPTURE.
- Reset asserted mid-run: all pins return to 0 immediately (asynchronously), count returns to 0, and no `result_valid` is produced.

## Test plan
- Write 3 symbols 0x05, 0x2A, 0x3F with HOLD=4, then start → exactly 3 `next_out` pulses of 4 cycles each, with matching `tape_data` stable 4 cycles before each. Then 1 `done_out` pulse of 4 cycles. `busy` lasts 32 cycles until WAIT.
- Empty buffer, start → no `next_out` pulse, and `done_out` rises at t+5. Then drive `compute_done_in` rising with `display_in`=0x5A3 → `result`=0x5A3 and one `result_valid` pulse.
- 65 writes → `full` after the 64th write. The 65th write is dropped: a run emits 64 `next_out` pulses.
- `compute_done_in` held high throughout with TIMEOUT=100 → no capture, `timeout_err`=1, return to IDLE. The next start clears `timeout_err`.
- Start, `wr_en`, and `clear` issued while busy → all ignored; the run and the buffer are unchanged.
- `reset_n` low during PULSE → `next_out`, `busy`, and `tape_data` go to 0 without waiting for a clock edge. After release: IDLE, count 0.

Source files
------------

// File: rtl/tape_loader.sv
// Host-side sequencer for the Turing-machine chip pin protocol:
// buffers tape symbols, strobes them out, then captures the display word.
module tape_loader #(
    parameter int WIDTH   = 6,
    parameter int DEPTH   = 64,
    parameter int HOLD    = 4,
    parameter int TIMEOUT = 65535
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             clear,
    input  logic             start,
    output logic             busy,
    output logic             full,
    output logic [WIDTH-1:0] tape_data,
    output logic             next_out,
    output logic             done_out,
    input  logic             compute_done_in,
    input  logic [10:0]      display_in,
    output logic [10:0]      result,
    output logic             result_valid,
    output logic             timeout_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_GAP,
        S_DONE,
        S_WAIT,
        S_CAPTURE
    } state_t;

    state_t state, state_n;

    logic [PW-1:0]    phase, phase_n;
    logic [CW-1:0]    index, index_n;
    logic [TW-1:0]    wcnt, wcnt_n;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] mem [DEPTH];

    logic        cd_s1, cd_s2, cd_d;
    logic [10:0] disp_s1, disp_s2;

    logic phase_end;
    logic rise;
    logic start_acc;
    logic wr_acc;
    logic err_set;

    assign phase_end = (phase == PW'(HOLD - 1));
    assign rise      = cd_s2 & ~cd_d;
    assign full      = (count == CW'(DEPTH));
    assign wr_acc    = (state == S_IDLE) && wr_en && !clear
                     && !full && !start_acc;

    always_comb begin
        state_n   = state;
        phase_n   = phase;
        index_n   = index;
        wcnt_n    = '0;
        start_acc = 1'b0;
        err_set   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && !clear) begin
                    start_acc = 1'b1;
                    index_n   = '0;
                    phase_n   = '0;
                    state_n   = (count != '0) ? S_SETUP : S_GAP;
                end
            end
            S_SETUP: begin
                if (phase_end) begin
                    phase_n = '0;
                    state_n = S_PULSE;
                end else begin
                    phase_n = phase + PW'(1);
                end
            end
            S_PULSE: begin
                if (phase_end) begin
                    phase_n = '0;
                    index_n = index + CW'(1);
                    state_n = (index + CW'(1) < count) ? S_SETUP : S_GAP;
                end else begin
                    phase_n = phase + PW'(1);
                end
            end
            S_GAP: begin
                if (phase_end) begin
                    phase_n = '0;
                    state_n = S_DONE;
                end else begin
                    phase_n = phase + PW'(1);
                end
            end
            S_DONE: begin
                if (phase_end) begin
                    phase_n = '0;
                    state_n = S_WAIT;
                end else begin
                    phase_n = phase + PW'(1);
                end
            end
            S_WAIT: begin
                // rise only fires after a synchronized low, so a level
                // already high on entry never counts as completion
                wcnt_n = wcnt + TW'(1);
                if (rise) begin
                    state_n = S_CAPTURE;
                end else if (wcnt == TW'(TIMEOUT - 1)) begin
                    err_set = 1'b1;
                    state_n = S_IDLE;
                end
            end
            S_CAPTURE: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
            phase <= '0;
            index <= '0;
            wcnt  <= '0;
        end else begin
            state <= state_n;
            phase <= phase_n;
            index <= index_n;
            wcnt  <= wcnt_n;
        end
    end

    // Pin outputs are registered from the next state so they line up
    // exactly with the state they belong to and never glitch.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy      <= 1'b0;
            next_out  <= 1'b0;
            done_out  <= 1'b0;
            tape_data <= '0;
        end else begin
            busy     <= (state_n != S_IDLE);
            next_out <= (state_n == S_PULSE);
            done_out <= (state_n == S_DONE);
            if (state_n == S_SETUP) begin
                tape_data <= mem[index_n[AW-1:0]];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            result       <= '0;
            result_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            result_valid <= (state_n == S_CAPTURE);
            if (state_n == S_CAPTURE) begin
                result <= disp_s2;
            end
            if (start_acc) begin
                timeout_err <= 1'b0;
            end else if (err_set) begin
                timeout_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (state == S_IDLE && clear) begin
            count <= '0;
        end else if (wr_acc) begin
            count <= count + CW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (wr_acc) begin
            mem[count[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cd_s1   <= 1'b0;
            cd_s2   <= 1'b0;
            cd_d    <= 1'b0;
            disp_s1 <= '0;
            disp_s2 <= '0;
        end else begin
            cd_s1   <= compute_done_in;
            cd_s2   <= cd_s1;
            cd_d    <= cd_s2;
            disp_s1 <= display_in;
            disp_s2 <= disp_s1;
        end
    end

endmodule
